// File: rtl/vga_scanline_scheduler.sv
// VGA sync/visible generation plus a 2x-vertical line-fetch scheduler with underrun detection.
// Optional: define VGA_SCANLINE_UNDERRUN_COUNT_EN to add a saturating 16-bit underrun counter.
module vga_scanline_scheduler #(
  parameter int WIDTH          = 800,
  parameter int HEIGHT         = 525,
  parameter int WIDTH_VISIBLE  = 640,
  parameter int HEIGHT_VISIBLE = 480,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int FETCH_LEAD     = 64,
  parameter int PIXEL_BITWIDTH = 11
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [PIXEL_BITWIDTH-1:0] i_x,
  input  logic [PIXEL_BITWIDTH-1:0] i_y,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_visible,
  output logic                      o_frame_start,
  output logic                      o_fetch_req,
  output logic [7:0]                o_fetch_line,
  input  logic                      i_fetch_ack,
`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
  output logic [15:0]               o_underrun_count,
`endif
  output logic                      o_line_ready,
  output logic                      o_underrun
);

  localparam int PW = PIXEL_BITWIDTH;

  localparam logic [PW-1:0] X_VIS    = PW'(WIDTH_VISIBLE);
  localparam logic [PW-1:0] Y_VIS    = PW'(HEIGHT_VISIBLE);
  localparam logic [PW-1:0] HS_START = PW'(WIDTH_VISIBLE + H_FRONT);
  localparam logic [PW-1:0] HS_END   = PW'(WIDTH_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [PW-1:0] VS_START = PW'(HEIGHT_VISIBLE + V_FRONT);
  localparam logic [PW-1:0] VS_END   = PW'(HEIGHT_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [PW-1:0] X_FETCH  = PW'(WIDTH - FETCH_LEAD);
  localparam logic [PW-1:0] X_LAST   = PW'(WIDTH - 1);
  localparam logic [PW-1:0] Y_LAST   = PW'(HEIGHT - 1);

  typedef enum logic {IDLE, REQ} fetch_state_e;

  // ---------------------------------------------------------------------------
  // Timing outputs: pure decode of x/y, one register stage.
  // ---------------------------------------------------------------------------
  logic hsync_d, vsync_d, visible_d, frame_start_d;
  logic hsync_q, vsync_q, visible_q, frame_start_q;

  always_comb begin
    hsync_d       = !((i_x >= HS_START) && (i_x < HS_END));
    vsync_d       = !((i_y >= VS_START) && (i_y < VS_END));
    visible_d     = (i_x < X_VIS) && (i_y < Y_VIS);
    frame_start_d = (i_x == '0) && (i_y == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      visible_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      frame_start_q <= frame_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch scheduler. Only even next lines are fetched, so each source line
  // feeds two displayed lines.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] next_y;
  logic          start_fetch;
  logic          underrun_set;
  logic [7:0]    fetch_line_d;

  fetch_state_e  state_q;
  logic          fetch_req_q;
  logic [7:0]    fetch_line_q;
  logic          line_ready_q;
  logic          underrun_q;

  always_comb begin
    next_y       = (i_y == Y_LAST) ? '0 : i_y + 1'b1;
    start_fetch  = (i_x == X_FETCH) && !next_y[0] && (next_y < Y_VIS);
    fetch_line_d = 8'(next_y >> 1);
    // An ack on the deadline cycle wins over the underrun.
    underrun_set = (state_q == REQ) && !i_fetch_ack && (i_x == X_LAST);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      fetch_req_q  <= 1'b0;
      fetch_line_q <= '0;
      line_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_fetch) begin
            state_q      <= REQ;
            fetch_req_q  <= 1'b1;
            fetch_line_q <= fetch_line_d;
            line_ready_q <= 1'b0;
          end
        end
        REQ: begin
          if (i_fetch_ack) begin
            state_q      <= IDLE;
            fetch_req_q  <= 1'b0;
            line_ready_q <= 1'b1;
          end else if (underrun_set) begin
            state_q     <= IDLE;
            fetch_req_q <= 1'b0;
            underrun_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          fetch_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
  logic [15:0] underrun_cnt_q;

  // Counts on the same edge that raises o_underrun so the two stay aligned.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      underrun_cnt_q <= '0;
    else if (underrun_set && (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
  end

  assign o_underrun_count = underrun_cnt_q;
`endif

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_visible     = visible_q;
  assign o_frame_start = frame_start_q;
  assign o_fetch_req   = fetch_req_q;
  assign o_fetch_line  = fetch_line_q;
  assign o_line_ready  = line_ready_q;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_vga_scanline_scheduler.sv
// Scoreboard bench for vga_scanline_scheduler: expected outputs queued per driven cycle.
module tb_vga_scanline_scheduler;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [10:0] i_x = '0;
  logic [10:0] i_y = '0;
  logic        i_fetch_ack = 1'b0;
  logic        o_hsync, o_vsync, o_visible, o_frame_start;
  logic        o_fetch_req, o_line_ready, o_underrun;
  logic [7:0]  o_fetch_line;
`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
  logic [15:0] o_underrun_count;
`endif

  vga_scanline_scheduler dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_x(i_x),
    .i_y(i_y),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_visible(o_visible),
    .o_frame_start(o_frame_start),
    .o_fetch_req(o_fetch_req),
    .o_fetch_line(o_fetch_line),
    .i_fetch_ack(i_fetch_ack),
`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
    .o_underrun_count(o_underrun_count),
`endif
    .o_line_ready(o_line_ready),
    .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit       hs, vs, vis, fs, req, rdy, ur;
    bit [7:0] line;
    int       cnt;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  // reference state for the fetch scheduler
  bit       m_req = 0;
  bit       m_rdy = 0;
  bit [7:0] m_line = 0;
  int       m_cnt = 0;

  // observed-event counters for directed checks
  int cnt_req, cnt_hs, cnt_vs, cnt_fs, cnt_ur;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    cnt_req = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; cnt_ur = 0;
  endtask

  task automatic step(input int x, input int y, input bit ack);
    exp_t e, o;
    int   ny;
    i_x = 11'(x);
    i_y = 11'(y);
    i_fetch_ack = ack;
    e.hs  = !(x >= 656 && x < 752);
    e.vs  = !(y >= 490 && y < 492);
    e.vis = (x < 640) && (y < 480);
    e.fs  = (x == 0) && (y == 0);
    e.ur  = 0;
    ny = (y == 524) ? 0 : y + 1;
    if (!m_req) begin
      if (x == 736 && (ny % 2) == 0 && ny < 480) begin
        m_req = 1; m_line = 8'(ny / 2); m_rdy = 0;
      end
    end else if (ack) begin
      m_req = 0; m_rdy = 1;
    end else if (x == 799) begin
      m_req = 0; e.ur = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    e.req = m_req; e.line = m_line; e.rdy = m_rdy; e.cnt = m_cnt;
    sbq.push_back(e);
    @(posedge i_clk);
    #1;
    o = sbq.pop_front();
    chk("hsync", o_hsync, o.hs);
    chk("vsync", o_vsync, o.vs);
    chk("visible", o_visible, o.vis);
    chk("frame_start", o_frame_start, o.fs);
    chk("fetch_req", o_fetch_req, o.req);
    chk("fetch_line", o_fetch_line, o.line);
    chk("line_ready", o_line_ready, o.rdy);
    chk("underrun", o_underrun, o.ur);
`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
    chk("underrun_count", o_underrun_count, o.cnt);
`endif
    cnt_req += int'(o_fetch_req);
    cnt_hs  += int'(!o_hsync);
    cnt_vs  += int'(!o_vsync);
    cnt_fs  += int'(o_frame_start);
    cnt_ur  += int'(o_underrun);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hsync"}, o_hsync, 1);
    chk({tag, "_vsync"}, o_vsync, 1);
    chk({tag, "_visible"}, o_visible, 0);
    chk({tag, "_frame_start"}, o_frame_start, 0);
    chk({tag, "_fetch_req"}, o_fetch_req, 0);
    chk({tag, "_fetch_line"}, o_fetch_line, 0);
    chk({tag, "_line_ready"}, o_line_ready, 0);
    chk({tag, "_underrun"}, o_underrun, 0);
`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
    chk({tag, "_count"}, o_underrun_count, 0);
`endif
  endtask

  int lines[8] = '{524, 0, 1, 479, 489, 490, 491, 492};
  int xs[8]    = '{0, 639, 640, 655, 656, 751, 752, 799};

  initial begin
    // reset drives known output values with no clock edge needed
    i_x = 11'd5; i_y = 11'd5;
    #2 i_reset = 1'b1;
    #1 check_reset_vals("reset");
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset = 1'b0;

    // full-width line sweeps; y=524 first exercises the underrun with no prior history
    foreach (lines[i]) begin
      clr_cnt();
      for (int x = 0; x < 800; x++) step(x, lines[i], 1'b0);
      chk("hs_low_cycles", cnt_hs, 96);
      if (lines[i] == 524) begin
        chk("ur_pulses", cnt_ur, 1);
        chk("ur_req_cycles", cnt_req, 63);
        chk("ur_req_dropped", o_fetch_req, 0);
        chk("ur_line_ready", o_line_ready, 0);
        chk("ur_line", o_fetch_line, 0);
`ifdef VGA_SCANLINE_UNDERRUN_COUNT_EN
        chk("ur_count", o_underrun_count, 1);
`endif
      end
    end

    // vertical sweep over every line with a handful of boundary columns
    clr_cnt();
    for (int y = 0; y < 525; y++)
      foreach (xs[j]) step(xs[j], y, 1'b0);
    chk("frame_start_pulses", cnt_fs, 1);
    chk("vs_low_cycles", cnt_vs, 16);

    // ack 5 cycles after request; ack lingers into IDLE and must be ignored
    clr_cnt();
    for (int x = 730; x < 800; x++) step(x, 1, (x >= 741 && x <= 743));
    chk("ack_req_cycles", cnt_req, 5);
    chk("ack_line", o_fetch_line, 1);
    chk("ack_line_ready", o_line_ready, 1);
    chk("ack_no_underrun", cnt_ur, 0);

    // ack on the deadline cycle beats the underrun
    clr_cnt();
    for (int x = 730; x < 800; x++) step(x, 3, (x == 799));
    chk("tie_no_underrun", cnt_ur, 0);
    chk("tie_line_ready", o_line_ready, 1);
    chk("tie_req_cycles", cnt_req, 63);
    chk("tie_line", o_fetch_line, 2);

    // odd next line and next line past the visible area never fetch
    clr_cnt();
    for (int x = 730; x < 800; x++) step(x, 0, 1'b0);
    for (int x = 730; x < 800; x++) step(x, 479, 1'b0);
    chk("nofetch_req_cycles", cnt_req, 0);

    // reset mid-request abandons it silently
    for (int x = 730; x < 741; x++) step(x, 5, 1'b0);
    chk("pre_reset_req", o_fetch_req, 1);
    i_reset = 1'b1;
    #1;
    check_reset_vals("midreq");
    m_req = 0; m_rdy = 0; m_line = 0; m_cnt = 0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset = 1'b0;
    clr_cnt();
    for (int x = 741; x < 800; x++) step(x, 5, 1'b0);
    chk("post_reset_req_cycles", cnt_req, 0);
    chk("post_reset_underrun", cnt_ur, 0);
    step(736, 5, 1'b0);
    chk("refetch_req", o_fetch_req, 1);
    chk("refetch_line", o_fetch_line, 3);
    for (int x = 737; x < 742; x++) step(x, 5, (x == 741));
    chk("refetch_ready", o_line_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
